// File: rtl/user_input_encoder.sv
// user_input_encoder
//   Producer side of the 4-bit user-input command bus used by the game
//   controllers. Raw board buttons are synchronized, debounced and
//   edge-detected. A small FSM then turns press events into single-cycle
//   one-hot commands, with auto-repeat for INC/DEC and a lockout after
//   PILE/RSV.
//
// Ports
//   w_clk         system clock
//   w_rst_n       asynchronous active-low reset
//   i_btn[3:0]    raw active-high buttons, async to w_clk: [3] INC, [2] DEC, [1] RSV, [0] PILE
//   o_user_input  registered one-hot command pulse, or 4'b0000 when idle
//   o_btn_level   debounced button levels, for LEDs
//   o_locked      high while input is locked out, waiting for all buttons to be released
module user_input_encoder #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic [3:0] i_btn,
  output logic [3:0] o_user_input,
  output logic [3:0] o_btn_level,
  output logic       o_locked
);

  localparam logic [3:0] CMD_INC  = 4'b1000;
  localparam logic [3:0] CMD_DEC  = 4'b0100;
  localparam logic [3:0] CMD_RSV  = 4'b0010;
  localparam logic [3:0] CMD_PILE = 4'b0001;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  level_prev_q, level_prev_d;
  logic [19:0] cnt_q [4];
  logic [19:0] cnt_d [4];
  logic [1:0]  state_q, state_d;
  logic [3:0]  held_q, held_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  user_input_q, user_input_d;

  logic [3:0]  press;
  logic [23:0] timer_inc;
  logic [23:0] timer_limit;

  // ---- stage: two-flop synchronizer ----
  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
  end

  // ---- stage: per-bit debounce ----
  // A level toggles only after DEBOUNCE_CYCLES consecutive mismatching
  // samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = 20'd0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  // ---- stage: press-edge detection ----
  always_comb begin
    level_prev_d = level_q;
    press        = level_q & ~level_prev_q;
  end

  // ---- stage: command FSM ----
  always_comb begin
    timer_inc   = (&timer_q) ? timer_q : timer_q + 24'd1;
    timer_limit = (state_q == ST_HELD) ? REPEAT_DELAY - 24'd1 : REPEAT_PERIOD - 24'd1;
  end

  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    timer_d      = timer_inc;
    user_input_d = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        timer_d = 24'd0;
        // Fixed priority PILE > INC > DEC > RSV; losers are dropped.
        if (press[0]) begin
          user_input_d = CMD_PILE;
          state_d      = ST_LOCK;
        end else if (press[3]) begin
          user_input_d = CMD_INC;
          held_d       = CMD_INC;
          state_d      = ST_HELD;
        end else if (press[2]) begin
          user_input_d = CMD_DEC;
          held_d       = CMD_DEC;
          state_d      = ST_HELD;
        end else if (press[1]) begin
          user_input_d = CMD_RSV;
          state_d      = ST_LOCK;
        end
      end
      ST_HELD, ST_REPEAT: begin
        // Release is tested first so it beats a coincident repeat expiry.
        if ((level_q & held_q) == 4'b0000) begin
          timer_d = 24'd0;
          state_d = (|level_q) ? ST_LOCK : ST_IDLE;
        end else if (timer_q == timer_limit) begin
          user_input_d = held_q;
          timer_d      = 24'd0;
          state_d      = ST_REPEAT;
        end
      end
      default: begin
        timer_d = 24'd0;
        if (level_q == 4'b0000) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      level_q      <= 4'b0000;
      level_prev_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 20'd0;
      end
      state_q      <= ST_IDLE;
      held_q       <= 4'b0000;
      timer_q      <= 24'd0;
      user_input_q <= 4'b0000;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q      <= state_d;
      held_q       <= held_d;
      timer_q      <= timer_d;
      user_input_q <= user_input_d;
    end
  end

  assign o_user_input = user_input_q;
  assign o_btn_level  = level_q;
  assign o_locked     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_user_input_encoder.sv
// tb_user_input_encoder
//   Directed bench for user_input_encoder with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=5. Expected pulses (cycle + code) are
//   queued as stimulus is issued; a monitor pops and compares on every
//   nonzero output. Level/lock checks are made inline.
//
//   Timing reference: inputs change at the falling edge after rising edge N,
//   so a new press reaches o_user_input after rising edge N+7 and a release
//   drops o_btn_level after rising edge N+6.
module tb_user_input_encoder;

  localparam logic [3:0] INC  = 4'b1000;
  localparam logic [3:0] PILE = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_btn;
  logic [3:0] o_user_input;
  logic [3:0] o_btn_level;
  logic       o_locked;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t sb_q[$];

  user_input_encoder #(
    .DEBOUNCE_CYCLES(20'd4),
    .REPEAT_DELAY   (24'd10),
    .REPEAT_PERIOD  (24'd5)
  ) dut (
    .w_clk       (clk),
    .w_rst_n     (rst_n),
    .i_btn       (i_btn),
    .o_user_input(o_user_input),
    .o_btn_level (o_btn_level),
    .o_locked    (o_locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every nonzero command must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_user_input != 4'b0000) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: cycle %0d got %b, none expected", cyc, o_user_input);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.code != o_user_input) begin
          bad++;
          $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                   o_user_input, cyc, e.code, e.cyc);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic go_to(input int k);
    while (cyc != k) @(negedge clk);
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    i_btn = 4'b0000;
    #1 rst_n = 1'b0;

    // Reset state
    go_to(2);
    check("reset_out", 32'(o_user_input), 32'h0);
    check("reset_level", 32'(o_btn_level), 32'h0);
    check("reset_locked", 32'(o_locked), 32'h0);
    rst_n = 1'b1;

    // Single press with auto-repeat; release coincides with a repeat expiry
    n = 4;
    go_to(n);
    i_btn = INC;
    expect_pulse(n + 7, INC);
    expect_pulse(n + 17, INC);
    expect_pulse(n + 22, INC);
    go_to(n + 7);
    check("single_level", 32'(o_btn_level), 32'h8);
    go_to(n + 20);
    i_btn = 4'b0000;
    go_to(n + 25);
    check("release_level_hold", 32'(o_btn_level), 32'h8);
    go_to(n + 26);
    check("release_level_fall", 32'(o_btn_level), 32'h0);
    go_to(n + 27);
    check("single_not_locked", 32'(o_locked), 32'h0);

    // Bounce on PILE, then settle high
    n = 40;
    go_to(n);
    for (int k = 0; k < 4; k++) begin
      i_btn = PILE;
      go_to(n + 4 * k + 2);
      i_btn = 4'b0000;
      go_to(n + 4 * k + 4);
    end
    check("bounce_level_low", 32'(o_btn_level), 32'h0);
    i_btn = PILE;
    expect_pulse(n + 23, PILE);
    go_to(n + 23);
    check("bounce_locked", 32'(o_locked), 32'h1);
    go_to(n + 30);
    i_btn = 4'b0000;
    go_to(n + 36);
    check("bounce_still_locked", 32'(o_locked), 32'h1);
    go_to(n + 37);
    check("bounce_unlocked", 32'(o_locked), 32'h0);

    // Lockout: DEC pressed while PILE holds the lock yields nothing
    n = 90;
    go_to(n);
    i_btn = PILE;
    expect_pulse(n + 7, PILE);
    go_to(n + 8);
    check("lock_locked", 32'(o_locked), 32'h1);
    go_to(n + 20);
    i_btn = 4'b0101;
    go_to(n + 29);
    check("lock_dec_level", 32'(o_btn_level), 32'h5);
    go_to(n + 30);
    i_btn = PILE;
    go_to(n + 50);
    i_btn = 4'b0000;
    go_to(n + 56);
    check("lock_still_locked", 32'(o_locked), 32'h1);
    go_to(n + 57);
    check("lock_unlocked", 32'(o_locked), 32'h0);

    // Simultaneous INC+DEC+PILE: only PILE wins
    n = 160;
    go_to(n);
    i_btn = 4'b1101;
    expect_pulse(n + 7, PILE);
    go_to(n + 8);
    check("simul_locked", 32'(o_locked), 32'h1);
    check("simul_level", 32'(o_btn_level), 32'hd);
    go_to(n + 10);
    i_btn = 4'b0000;
    go_to(n + 17);
    check("simul_unlocked", 32'(o_locked), 32'h0);

    // PILE ignored while INC held; INC release with PILE held goes to LOCK
    n = 190;
    go_to(n);
    i_btn = INC;
    expect_pulse(n + 7, INC);
    expect_pulse(n + 17, INC);
    expect_pulse(n + 22, INC);
    expect_pulse(n + 27, INC);
    go_to(n + 9);
    i_btn = 4'b1001;
    go_to(n + 25);
    i_btn = PILE;
    go_to(n + 31);
    check("ignored_not_yet_locked", 32'(o_locked), 32'h0);
    go_to(n + 32);
    check("ignored_locked", 32'(o_locked), 32'h1);
    go_to(n + 40);
    i_btn = 4'b0000;
    go_to(n + 47);
    check("ignored_unlocked", 32'(o_locked), 32'h0);

    // Asynchronous reset mid-REPEAT, INC still held afterwards
    n = 250;
    go_to(n);
    i_btn = INC;
    expect_pulse(n + 7, INC);
    expect_pulse(n + 17, INC);
    expect_pulse(n + 22, INC);
    go_to(n + 22);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(o_user_input), 32'h0);
    check("async_rst_level", 32'(o_btn_level), 32'h0);
    check("async_rst_locked", 32'(o_locked), 32'h0);
    go_to(n + 25);
    rst_n = 1'b1;
    expect_pulse(n + 32, INC);
    go_to(n + 33);
    i_btn = 4'b0000;
    go_to(n + 45);
    check("post_rst_level", 32'(o_btn_level), 32'h0);
    check("post_rst_locked", 32'(o_locked), 32'h0);

    // Asynchronous reset while locked
    n = 300;
    go_to(n);
    i_btn = PILE;
    expect_pulse(n + 7, PILE);
    go_to(n + 10);
    check("lockrst_locked", 32'(o_locked), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("lockrst_dropped", 32'(o_locked), 32'h0);
    i_btn = 4'b0000;
    go_to(n + 12);
    rst_n = 1'b1;
    go_to(n + 20);
    check("lockrst_idle", 32'(o_locked), 32'h0);

    go_to(330);
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL pulse_missing: got none, expected %b at cycle %0d", e.code, e.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/user_input_encoder.md
Name: user_input_encoder

Overview:
- Producer side of the 4-bit user-input command bus consumed by the game controllers (one-person and two-person play).
- Synchronizes and debounces the raw board buttons, then detects press edges.
- Emits single-cycle one-hot commands: INC 4'b1000, DEC 4'b0100, RSV 4'b0010, PILE 4'b0001, idle 4'b0000.
- Holding INC or DEC auto-repeats. After a PILE, all further input is locked out until every button is released, so one physical press never yields two moves.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000: consecutive cycles a synchronized button must differ from its debounced state before that state toggles; must be >=1.
- REPEAT_DELAY, 24'd5000000: cycles from the first INC/DEC pulse to the first repeat pulse; must be >=2.
- REPEAT_PERIOD, 24'd2500000: cycles between subsequent repeat pulses; must be >=2.

Ports:
- w_clk  input  1  system clock.
- w_rst_n  input  1  asynchronous, active-low reset.
- i_btn  input  4  raw active-high buttons, asynchronous to w_clk: [3] INC, [2] DEC, [1] RSV, [0] PILE.
- o_user_input  output  4  registered one-hot command pulse, or 0.
- o_btn_level  output  4  debounced button levels, for LEDs.
- o_locked  output  1  high while in LOCK.

Behaviour:
- Reset (asynchronous, w_rst_n=0): clear synchronizers, debounced state, counters and timer. o_user_input=0, o_btn_level=0, o_locked=0, FSM=IDLE.
- Reset mid-hold: outputs drop immediately. A button still held after release of reset re-debounces from 0 and produces exactly one new press event.
- Synchronizer: two flops per bit.
- Debounce, per bit:
  - While sync2 != level, the counter increments; when sync2 == level, the counter clears.
  - When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, level toggles and the counter clears.
- Press event: debounced level rising 0->1, valid for one cycle.
- Latency: raw high sampled at edge 0 puts the pulse on o_user_input after edge DEBOUNCE_CYCLES+2, for exactly one cycle.
- Arbitration when several press events occur in the same cycle: PILE > INC > DEC > RSV. Losing events are discarded, not queued.
- FSM states and transitions:
  - IDLE: on a winning press event, drive its code for 1 cycle. INC/DEC go to HELD (record held bit, timer=0). PILE/RSV go to LOCK.
  - HELD: timer increments each cycle.
    - If the held level falls: go to LOCK if any level is still 1, else IDLE.
    - Else, when the timer reaches REPEAT_DELAY-1: pulse the held code, timer=0, go to REPEAT.
  - REPEAT: same as HELD, but using REPEAT_PERIOD-1; stays in REPEAT after each pulse.
  - LOCK: output 0, o_locked=1. Leave for IDLE on the first cycle in which all four levels are 0.
- In HELD/REPEAT, press events on other buttons are ignored, including PILE.
- Release and repeat expiry in the same cycle: release wins, no pulse.
- Output guarantees:
  - o_user_input is never multi-hot.
  - Two nonzero pulses are always separated by >=1 zero cycle (guaranteed by REPEAT_* >=2 and the FSM transitions).
- Widths:
  - Debounce counters are 20 bits.
  - The repeat timer is 24 bits and saturates, never wrapping; it is cleared on every state change.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Single press: i_btn=4'b1000 held 20 cycles, then 0 -> one cycle of 4'b1000 at edge 6, then repeats 10 cycles after that pulse and every 5 cycles thereafter while held; o_btn_level[3] falls 6 cycles after release.
- Bounce: PILE toggled 1/0 every 2 cycles for 16 cycles, then held high -> no pulse during toggling; exactly one 4'b0001 DEBOUNCE_CYCLES+2 edges after it settles.
- Lockout: PILE held 50 cycles -> one 4'b0001 pulse, o_locked=1 until the debounced release; DEC pressed during the lock -> no output.
- Simultaneous press: i_btn 0->4'b1101 in one cycle -> only 4'b0001 is emitted, then LOCK.
- Ignored button: hold INC; press PILE while INC is held (HELD state) -> PILE ignored, INC repeats continue; release INC with PILE still held -> LOCK, no output.
- Async reset: w_rst_n pulled low mid-REPEAT -> o_user_input=0 and o_locked=0 immediately, without waiting for a clock; after reset is released with INC still held -> exactly one 4'b1000 at edge 6.
